// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) in front of a single-port
// synchronous RAM; round-robin on ties, registered grant/valid/RAM-side outputs.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_w_en,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

  state_t state;
  owner_t owner;
  owner_t last_owner;
  logic   acc_we;
  logic   pick_ls;

  // LS wins when it is the only requester, or on a tie when IF was served last.
  always_comb begin
    pick_ls = ls_req && (!if_req || (last_owner == OWN_IF));
  end

  // Grant and RAM-side outputs are loaded on the IDLE->ACCESS edge so they are
  // valid exactly during the ACCESS cycle; rvalid is loaded on ACCESS->RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      last_owner <= OWN_IF;
      acc_we     <= 1'b0;
      if_gnt     <= 1'b0;
      ls_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      ram_addr   <= '0;
      ram_w_en   <= 1'b0;
      ram_wdata  <= '0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      ram_addr  <= '0;
      ram_w_en  <= 1'b0;
      ram_wdata <= '0;
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state <= ACCESS;
            if (pick_ls) begin
              owner     <= OWN_LS;
              acc_we    <= ls_we;
              ls_gnt    <= 1'b1;
              ram_addr  <= ls_addr;
              ram_w_en  <= ls_we;
              ram_wdata <= ls_we ? ls_wdata : '0;
            end else begin
              owner    <= OWN_IF;
              acc_we   <= 1'b0;
              if_gnt   <= 1'b1;
              ram_addr <= if_addr;
            end
          end
        end
        ACCESS: begin
          last_owner <= owner;
          if (acc_we) begin
            state <= IDLE;
          end else begin
            state <= RESP;
            if (owner == OWN_LS) ls_rvalid <= 1'b1;
            else                 if_rvalid <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM data arrives in RESP, so read data is steered combinationally from the RAM.
  always_comb begin
    if_rdata = '0;
    ls_rdata = '0;
    if (state == RESP) begin
      if (owner == OWN_LS) ls_rdata = ram_rdata;
      else                 if_rdata = ram_rdata;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural synchronous RAM, expected-event
// scoreboard with cycle stamps, one task per scenario.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [31:0]       if_rdata;
  logic              ls_req = 1'b0;
  logic              ls_we = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [31:0]       ls_wdata = '0;
  logic              ls_gnt, ls_rvalid;
  logic [31:0]       ls_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_w_en;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic              busy;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [0:(1<<ADDR_W)-1];
  logic [31:0] shadow [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (ram_w_en) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          ls;
    bit          rv;
    bit          we;
    logic [ADDR_W-1:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  bit  auto_drop = 1'b1;

  task automatic push_ev(input bit ls, input bit rv, input bit we,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                         input int at);
    ev_t e;
    e.ls = ls; e.rv = rv; e.we = we; e.addr = addr; e.data = data; e.cyc = at;
    expq.push_back(e);
  endtask

  // Scoreboard consumer: steps n cycles, pops one expected event per DUT event.
  task automatic drain(input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if ((if_gnt && ls_gnt) || (if_rvalid && ls_rvalid)) begin
        errors++;
        $display("FAIL onehot cyc=%0d gnt=%b%b rvalid=%b%b required at most one each",
                 cyc, if_gnt, ls_gnt, if_rvalid, ls_rvalid);
      end
      if (!if_gnt && !ls_gnt) begin
        checks++;
        if (ram_w_en !== 1'b0 || ram_addr !== '0) begin
          errors++;
          $display("FAIL idle_ram cyc=%0d w_en=%b addr=%h required 0/0", cyc, ram_w_en, ram_addr);
        end
      end
      if (if_gnt || ls_gnt || if_rvalid || ls_rvalid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected cyc=%0d gnt=%b%b rvalid=%b%b required none",
                   cyc, if_gnt, ls_gnt, if_rvalid, ls_rvalid);
        end else begin
          e = expq.pop_front();
          if ((ls_gnt || ls_rvalid) !== e.ls || (if_rvalid || ls_rvalid) !== e.rv || cyc != e.cyc) begin
            errors++;
            $display("FAIL event cyc=%0d ls=%b rv=%b required cyc=%0d ls=%b rv=%b",
                     cyc, ls_gnt || ls_rvalid, if_rvalid || ls_rvalid, e.cyc, e.ls, e.rv);
          end else if (!e.rv) begin
            checks++;
            if (ram_addr !== e.addr || ram_w_en !== e.we || ram_wdata !== (e.we ? e.data : 32'h0)) begin
              errors++;
              $display("FAIL access cyc=%0d addr=%h w_en=%b wdata=%h required %h/%b/%h",
                       cyc, ram_addr, ram_w_en, ram_wdata, e.addr, e.we, e.we ? e.data : 32'h0);
            end
          end else begin
            checks++;
            if ((e.ls ? ls_rdata : if_rdata) !== e.data || (e.ls ? if_rdata : ls_rdata) !== 32'h0) begin
              errors++;
              $display("FAIL rdata cyc=%0d if=%h ls=%h required owner=%h other=0",
                       cyc, if_rdata, ls_rdata, e.data);
            end
          end
        end
      end
      if (auto_drop && if_gnt) if_req = 1'b0;
      if (auto_drop && ls_gnt) ls_req = 1'b0;
    end
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL %s_missing pending=%0d required 0", name, expq.size());
      expq.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
         ram_addr, ram_w_en, ram_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL %s gnt=%b%b rv=%b%b rd=%h/%h addr=%h we=%b wd=%h busy=%b required all 0",
               name, if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_rdata, ls_rdata,
               ram_addr, ram_w_en, ram_wdata, busy);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    drain(3);
    check_outputs_zero("post_reset_idle");
  endtask

  task automatic test_fetch();
    if_addr = 11'h010;
    if_req  = 1'b1;
    push_ev(1'b0, 1'b0, 1'b0, 11'h010, 32'h0, cyc + 1);
    push_ev(1'b0, 1'b1, 1'b0, 11'h010, shadow[11'h010], cyc + 2);
    drain(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_busy busy=%b required 1", busy);
    end
    drain(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle busy=%b required 0", busy);
    end
    check_empty("fetch");
  endtask

  task automatic test_store_load();
    ls_addr  = 11'h020;
    ls_wdata = 32'hDEADBEEF;
    ls_we    = 1'b1;
    ls_req   = 1'b1;
    shadow[11'h020] = 32'hDEADBEEF;
    push_ev(1'b1, 1'b0, 1'b1, 11'h020, 32'hDEADBEEF, cyc + 1);
    drain(3);
    check_empty("store");
    ls_we  = 1'b0;
    ls_req = 1'b1;
    push_ev(1'b1, 1'b0, 1'b0, 11'h020, 32'h0, cyc + 1);
    push_ev(1'b1, 1'b1, 1'b0, 11'h020, shadow[11'h020], cyc + 2);
    drain(4);
    check_empty("load");
  endtask

  task automatic test_tie();
    apply_reset();
    drain(2);
    auto_drop = 1'b0;
    if_addr = 11'h100;
    ls_addr = 11'h200;
    ls_we   = 1'b0;
    if_req  = 1'b1;
    ls_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_ev(k % 2 == 0, 1'b0, 1'b0, (k % 2 == 0) ? 11'h200 : 11'h100, 32'h0, cyc + 1 + 3 * k);
      push_ev(k % 2 == 0, 1'b1, 1'b0, 11'h0,
              (k % 2 == 0) ? shadow[11'h200] : shadow[11'h100], cyc + 2 + 3 * k);
    end
    drain(10);
    if_req = 1'b0;
    ls_req = 1'b0;
    drain(4);
    auto_drop = 1'b1;
    check_empty("tie");
  endtask

  task automatic test_drop();
    ls_addr = 11'h123;
    ls_we   = 1'b0;
    ls_req  = 1'b1;
    push_ev(1'b1, 1'b0, 1'b0, 11'h123, 32'h0, cyc + 1);
    push_ev(1'b1, 1'b1, 1'b0, 11'h0, shadow[11'h123], cyc + 2);
    drain(1);
    ls_req = 1'b0;
    drain(4);
    check_empty("drop");
  endtask

  task automatic test_reset_mid_resp();
    if_addr = 11'h010;
    if_req  = 1'b1;
    push_ev(1'b0, 1'b0, 1'b0, 11'h010, 32'h0, cyc + 1);
    drain(1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("mid_resp_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drain(4);
    check_empty("mid_resp");
    if_addr = 11'h010;
    if_req  = 1'b1;
    push_ev(1'b0, 1'b0, 1'b0, 11'h010, 32'h0, cyc + 1);
    push_ev(1'b0, 1'b1, 1'b0, 11'h0, shadow[11'h010], cyc + 2);
    drain(4);
    check_empty("after_reset");
  endtask

  initial begin
    for (int unsigned a = 0; a < (1 << ADDR_W); a++) begin
      mem[a]    = $urandom;
      shadow[a] = mem[a];
    end
    mem[11'h010]    = 32'hE3A01005;
    shadow[11'h010] = 32'hE3A01005;
    #1 check_outputs_zero("reset_t0");
    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_drop();
    test_reset_mid_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
